// File: rtl/dram_ctrl_pkg.sv
// Shared command encodings and scheduler state type for the DRAM controller.
// cmd_of maps a scheduler state to the command driven while in that state.
package dram_ctrl_pkg;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ACT,
        ST_RW,
        ST_WAIT,
        ST_REF_PREA,
        ST_REF,
        ST_REF_WAIT
    } state_t;

    // Each command-issuing state drives its command for exactly one cycle.
    function automatic logic [2:0] cmd_of(input state_t s, input logic rw);
        case (s)
            ST_PRE:      cmd_of = CMD_PRE;
            ST_ACT:      cmd_of = CMD_ACT;
            ST_RW:       cmd_of = rw ? CMD_WR : CMD_RD;
            ST_REF_PREA: cmd_of = CMD_PREA;
            ST_REF:      cmd_of = CMD_REF;
            default:     cmd_of = CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row table: valid bit plus open row, combinational lookup,
// single-bank set on ACT and clear-all on PREA.
module dram_open_row_table #(
    parameter int  NUM_OF_BANKS = 8,
    parameter int  NUM_OF_ROWS  = 128,
    localparam int BW           = $clog2(NUM_OF_BANKS),
    localparam int RW           = $clog2(NUM_OF_ROWS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [BW-1:0] lookup_bank,
    input  logic [RW-1:0] lookup_row,
    output logic          lookup_open,
    output logic          lookup_hit,
    output logic          any_open,
    input  logic          set_en,
    input  logic [BW-1:0] set_bank,
    input  logic [RW-1:0] set_row,
    input  logic          clr_all
);

    logic [NUM_OF_BANKS-1:0] valid_vec;
    logic [RW-1:0]           row_arr [NUM_OF_BANKS];

    generate
        for (genvar gi = 0; gi < NUM_OF_BANKS; gi++) begin : g_bank
            logic          valid_reg;
            logic [RW-1:0] row_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    valid_reg <= 1'b0;
                    row_reg   <= '0;
                end else if (clr_all) begin
                    valid_reg <= 1'b0;
                end else if (set_en && set_bank == BW'(gi)) begin
                    valid_reg <= 1'b1;
                    row_reg   <= set_row;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign row_arr[gi]   = row_reg;
        end
    endgenerate

    assign lookup_open = valid_vec[lookup_bank];
    assign lookup_hit  = lookup_open && (row_arr[lookup_bank] == lookup_row);
    assign any_open    = |valid_vec;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Turns one request at a time into ACT/RD/WR/PRE commands, interleaving
// refresh between requests, with one shared wait counter for tRCD/tRP/tRFC.
module dram_cmd_scheduler
    import dram_ctrl_pkg::*;
#(
    parameter int  NUM_OF_BANKS = 8,
    parameter int  NUM_OF_ROWS  = 128,
    parameter int  NUM_OF_COLS  = 8,
    parameter int  T_RCD        = 2,
    parameter int  T_RP         = 2,
    parameter int  T_RFC        = 4,
    localparam int BW           = $clog2(NUM_OF_BANKS),
    localparam int RW           = $clog2(NUM_OF_ROWS),
    localparam int CW           = $clog2(NUM_OF_COLS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rw,
    input  logic [BW-1:0] req_bank,
    input  logic [RW-1:0] req_row,
    input  logic [CW-1:0] req_col,
    input  logic          refresh_req,
    output logic          refresh_ack,
    output logic [2:0]    cmd,
    output logic [BW-1:0] cmd_bank,
    output logic [RW-1:0] cmd_row,
    output logic [CW-1:0] cmd_col,
    output logic          done
);

    localparam int T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
    localparam int CNTW   = $clog2(T_MAX + 1);

    state_t          state_reg, state_next, tgt_reg, tgt_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic            ack_next;
    logic            lat_rw_reg;
    logic [BW-1:0]   lat_bank_reg;
    logic [RW-1:0]   lat_row_reg;
    logic [CW-1:0]   lat_col_reg;
    logic            cur_rw;
    logic [BW-1:0]   cur_bank;
    logic [RW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic            tbl_open, tbl_hit, tbl_any_open;
    logic            handshake;

    assign req_ready = (state_reg == ST_IDLE) && !refresh_req;
    assign handshake = req_valid && req_ready;

    // The first command of a request issues straight from IDLE, before the latch is loaded.
    assign cur_rw   = (state_reg == ST_IDLE) ? req_rw   : lat_rw_reg;
    assign cur_bank = (state_reg == ST_IDLE) ? req_bank : lat_bank_reg;
    assign cur_row  = (state_reg == ST_IDLE) ? req_row  : lat_row_reg;
    assign cur_col  = (state_reg == ST_IDLE) ? req_col  : lat_col_reg;

    dram_open_row_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .NUM_OF_ROWS  (NUM_OF_ROWS)
    ) u_table (
        .clk         (clk),
        .rst_b       (rst_b),
        .lookup_bank (req_bank),
        .lookup_row  (req_row),
        .lookup_open (tbl_open),
        .lookup_hit  (tbl_hit),
        .any_open    (tbl_any_open),
        .set_en      (state_next == ST_ACT),
        .set_bank    (cur_bank),
        .set_row     (cur_row),
        .clr_all     (state_next == ST_REF_PREA)
    );

    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (refresh_req)
                    state_next = tbl_any_open ? ST_REF_PREA : ST_REF;
                else if (req_valid)
                    state_next = tbl_hit ? ST_RW : (tbl_open ? ST_PRE : ST_ACT);
            end
            ST_PRE, ST_REF_PREA: begin
                tgt_next = (state_reg == ST_PRE) ? ST_ACT : ST_REF;
                if (T_RP == 1) begin
                    state_next = tgt_next;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = CNTW'(T_RP - 1);
                end
            end
            ST_ACT: begin
                tgt_next = ST_RW;
                if (T_RCD == 1) begin
                    state_next = ST_RW;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = CNTW'(T_RCD - 1);
                end
            end
            ST_RW: state_next = ST_IDLE;
            ST_WAIT: begin
                if (cnt_reg <= 1)
                    state_next = tgt_reg;
                else
                    cnt_next = cnt_reg - 1'b1;
            end
            ST_REF: begin
                state_next = ST_REF_WAIT;
                cnt_next   = CNTW'(T_RFC - 1);
                ack_next   = (T_RFC == 1);
            end
            // The final REF_WAIT cycle carries refresh_ack, so IDLE follows it.
            ST_REF_WAIT: begin
                if (cnt_reg == 0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    ack_next = (cnt_reg == 1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= ST_IDLE;
            tgt_reg      <= ST_IDLE;
            cnt_reg      <= '0;
            lat_rw_reg   <= 1'b0;
            lat_bank_reg <= '0;
            lat_row_reg  <= '0;
            lat_col_reg  <= '0;
            cmd          <= CMD_NOP;
            cmd_bank     <= '0;
            cmd_row      <= '0;
            cmd_col      <= '0;
            done         <= 1'b0;
            refresh_ack  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tgt_reg     <= tgt_next;
            cnt_reg     <= cnt_next;
            cmd         <= cmd_of(state_next, cur_rw);
            done        <= (state_next == ST_RW);
            refresh_ack <= ack_next;
            if (handshake) begin
                lat_rw_reg   <= req_rw;
                lat_bank_reg <= req_bank;
                lat_row_reg  <= req_row;
                lat_col_reg  <= req_col;
            end
            if (state_next == ST_PRE || state_next == ST_ACT || state_next == ST_RW)
                cmd_bank <= cur_bank;
            if (state_next == ST_ACT)
                cmd_row <= cur_row;
            if (state_next == ST_RW)
                cmd_col <= cur_col;
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench: request vectors plus refresh/reset sequences; expected commands are
// queued with their issue cycle and matched as the DUT emits them.
module tb_dram_cmd_scheduler;

    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int ACK_CODE = 7;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [2:0] req_bank = '0;
    logic [6:0] req_row = '0;
    logic [2:0] req_col = '0;
    logic       refresh_req = 1'b0;
    logic       refresh_ack;
    logic [2:0] cmd;
    logic [2:0] cmd_bank;
    logic [6:0] cmd_row;
    logic [2:0] cmd_col;
    logic       done;

    dram_cmd_scheduler #(
        .NUM_OF_BANKS (8), .NUM_OF_ROWS (128), .NUM_OF_COLS (8),
        .T_RCD (TRCD), .T_RP (TRP), .T_RFC (TRFC)
    ) dut (
        .clk (clk), .rst_b (rst_b),
        .req_valid (req_valid), .req_ready (req_ready), .req_rw (req_rw),
        .req_bank (req_bank), .req_row (req_row), .req_col (req_col),
        .refresh_req (refresh_req), .refresh_ack (refresh_ack),
        .cmd (cmd), .cmd_bank (cmd_bank), .cmd_row (cmd_row), .cmd_col (cmd_col),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int code;
        int bank;
        int row;
        int col;
    } exp_t;

    typedef struct {
        bit rw;
        int bank;
        int row;
        int col;
        int kind;   // 0 hit, 1 closed, 2 conflict
    } vec_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ack_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int c, input int code, input int b, input int r, input int col);
        exp_t e;
        e.cyc = c; e.code = code; e.bank = b; e.row = r; e.col = col;
        sbq.push_back(e);
    endtask

    // Monitor: every issued command and every refresh_ack must match the queue head.
    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missed_event: code=%0d expected at cycle %0d, not seen by cycle %0d",
                         mon_e.code, mon_e.cyc, cyc);
            end
            if (cmd != 3'd0) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_cmd: actual cmd=%0d bank=%0d at cycle %0d, expected none",
                             cmd, cmd_bank, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    mon_ok = (mon_e.cyc == cyc) && (mon_e.code == int'(cmd)) &&
                             (mon_e.bank < 0 || mon_e.bank == int'(cmd_bank)) &&
                             (mon_e.row  < 0 || mon_e.row  == int'(cmd_row)) &&
                             (mon_e.col  < 0 || mon_e.col  == int'(cmd_col));
                    if (!mon_ok) begin
                        n_fail++;
                        $display("FAIL cmd_issue: actual cyc=%0d cmd=%0d bank=%0d row=%0d col=%0d expected cyc=%0d cmd=%0d bank=%0d row=%0d col=%0d",
                                 cyc, cmd, cmd_bank, cmd_row, cmd_col,
                                 mon_e.cyc, mon_e.code, mon_e.bank, mon_e.row, mon_e.col);
                    end
                end
                chk("done_with_rw", int'(done), int'(cmd == 3'd2 || cmd == 3'd3));
            end else if (done) begin
                chk("done_without_rw", int'(done), 0);
            end
            if (refresh_ack) begin
                last_ack_cyc = cyc;
                n_checks++;
                if (sbq.size() == 0 || sbq[0].code != ACK_CODE || sbq[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL refresh_ack: actual pulse at cycle %0d, expected head=%0d at cycle %0d",
                             cyc, (sbq.size() != 0) ? sbq[0].code : -1,
                             (sbq.size() != 0) ? sbq[0].cyc : -1);
                end
                if (sbq.size() != 0 && sbq[0].code == ACK_CODE) void'(sbq.pop_front());
            end
        end
    end

    task automatic do_req(input bit rw, input int b, input int r, input int c,
                          input int kind, output int k);
        int t;
        int rwc;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw;
        req_bank = 3'(b); req_row = 7'(r); req_col = 3'(c);
        #1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!req_ready) begin
            chk("handshake_timeout", 0, 1);
            req_valid = 1'b0;
            k = -1;
            return;
        end
        k = cyc;
        rwc = rw ? 3 : 2;
        case (kind)
            0: push(k + 1, rwc, b, -1, c);
            1: begin
                push(k + 1, 1, b, r, -1);
                push(k + 1 + TRCD, rwc, b, -1, c);
            end
            default: begin
                push(k + 1, 4, b, -1, -1);
                push(k + 1 + TRP, 1, b, r, -1);
                push(k + 1 + TRP + TRCD, rwc, b, -1, c);
            end
        endcase
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_low_after_hs", int'(req_ready), 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 60) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_pending", sbq.size(), 0);
        sbq.delete();
    endtask

    vec_t vecs[8];
    int   k, k2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rw: 1'b0, bank: 2, row: 5,   col: 3, kind: 1};
        vecs[1] = '{rw: 1'b0, bank: 2, row: 5,   col: 7, kind: 0};
        vecs[2] = '{rw: 1'b1, bank: 2, row: 9,   col: 1, kind: 2};
        vecs[3] = '{rw: 1'b1, bank: 5, row: 0,   col: 0, kind: 1};
        vecs[4] = '{rw: 1'b0, bank: 5, row: 0,   col: 7, kind: 0};
        vecs[5] = '{rw: 1'b0, bank: 5, row: 127, col: 4, kind: 2};
        vecs[6] = '{rw: 1'b1, bank: 7, row: 127, col: 7, kind: 1};
        vecs[7] = '{rw: 1'b1, bank: 2, row: 9,   col: 6, kind: 0};

        // Reset values; req_ready follows !refresh_req even in reset.
        rst_b = 1'b0;
        refresh_req = 1'b1;
        #1;
        chk("rst_ready_refresh", int'(req_ready), 0);
        refresh_req = 1'b0;
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack", int'(refresh_ack), 0);
        chk("rst_cmd_fields", int'({cmd_bank, cmd_row, cmd_col}), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        // Request vectors: hit, closed, conflict, boundary banks/rows.
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].rw, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].kind, k);
            drain();
            chk("ready_after_rw", int'(req_ready), 1);
        end

        // Refresh wins over a pending request while a bank is open.
        @(negedge clk);
        refresh_req = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_bank = 3'd2; req_row = 7'd9; req_col = 3'd2;
        #1;
        chk("ready_low_refresh", int'(req_ready), 0);
        k = cyc;
        push(k + 1, 5, -1, -1, -1);
        push(k + 1 + TRP, 6, -1, -1, -1);
        push(k + 1 + TRP + TRFC, ACK_CODE, -1, -1, -1);
        drain();
        refresh_req = 1'b0;
        do_req(1'b0, 2, 9, 2, 1, k2);
        chk("accept_after_ack", k2, last_ack_cyc + 1);
        drain();

        // Refresh arriving during tRCD waits for the read to finish.
        do_req(1'b0, 4, 3, 1, 1, k);
        @(posedge clk); #1;
        refresh_req = 1'b1;
        push(k + 5, 5, -1, -1, -1);
        push(k + 5 + TRP, 6, -1, -1, -1);
        push(k + 5 + TRP + TRFC, ACK_CODE, -1, -1, -1);
        drain();
        refresh_req = 1'b0;
        #1;
        chk("ready_after_refresh", int'(req_ready), 1);

        // All banks closed: REF without PREA.
        @(negedge clk);
        refresh_req = 1'b1;
        #1;
        k = cyc;
        push(k + 1, 6, -1, -1, -1);
        push(k + 1 + TRFC, ACK_CODE, -1, -1, -1);
        drain();
        refresh_req = 1'b0;

        // Reset during PRE abandons the request and clears the table.
        do_req(1'b0, 1, 10, 4, 1, k);
        drain();
        do_req(1'b1, 1, 11, 5, 2, k);
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_cmd", int'(cmd), 0);
        chk("rst_mid_bank", int'(cmd_bank), 0);
        chk("rst_mid_done", int'(done), 0);
        sbq.delete();
        @(negedge clk);
        rst_b = 1'b1;
        do_req(1'b1, 1, 11, 5, 1, k);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Sequences one translated DRAM request at a time into legal bank commands (ACT/RD/WR/PRE) and arbitrates that traffic against periodic refresh. It sits between the address-buffer output (bank/row/col fields) and the bank/row/col decoders. It keeps an open-row table per bank and enforces the tRCD/tRP/tRFC spacing with a single wait counter. Refresh has priority over new requests but never preempts a request already in progress.

## Interface
- NUM_OF_BANKS, 8: number of banks; BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128: rows per bank; RW = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8: columns per row; CW = $clog2(NUM_OF_COLS)
- T_RCD, 2: cycles from ACT to RD/WR (≥1)
- T_RP, 2: cycles from PRE/PREA to next ACT/REF (≥1)
- T_RFC, 4: cycles from REF to next command (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler accepts request this cycle
- req_rw  in  1  1 = write, 0 = read
- req_bank  in  BW  target bank
- req_row  in  RW  target row
- req_col  in  CW  target column
- refresh_req  in  1  level; refresh due (from refresh counter)
- refresh_ack  out  1  one-cycle pulse when refresh complete
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
- cmd_bank  out  BW  bank for ACT/RD/WR/PRE
- cmd_row  out  RW  row for ACT
- cmd_col  out  CW  column for RD/WR
- done  out  1  one-cycle pulse, coincident with RD/WR issue

## Operation
- States: IDLE, PRE, ACT, RW, WAIT, REF_PREA, REF, REF_WAIT.
- req_ready = (state==IDLE) && !refresh_req; combinational.
- IDLE with refresh_req high: go to REF_PREA if any bank is open, else REF. Pending req_valid is held (not accepted).
- IDLE with req_valid && req_ready: latch rw/bank/row/col and look up the table:
  - hit (bank open, same row) → RW
  - closed → ACT
  - conflict (bank open, other row) → PRE
- PRE: issue PRE (cmd_bank). Wait T_RP, then ACT.
- ACT: issue ACT (bank, row). Mark the table entry open with that row. Wait T_RCD, then RW.
- RW: issue RD or WR (bank, col), pulse done, return to IDLE. The row stays open (open-page policy).
- REF_PREA: issue PREA, invalidate all table entries. Wait T_RP, then REF.
- REF: issue REF. Wait T_RFC, then pulse refresh_ack and return to IDLE.
- Wait semantics: after a command with delay T, drive NOP for T-1 cycles. The next command issues exactly T cycles after the previous one.
- The wait counter is sized $clog2(max(T_RCD,T_RP,T_RFC)+1).
- refresh_req rising mid-request is serviced only after the current RW completes.
- cmd_bank/row/col hold their last value during NOP; only cmd qualifies them.

## Timing
- All outputs except req_ready are registered.
- Reset (rst_b low, async):
  - state IDLE, all table entries invalid, wait counter 0
  - cmd = NOP, cmd_bank/row/col = 0, done = 0, refresh_ack = 0
  - req_ready follows !refresh_req
- Reset mid-operation abandons the request; no command is completed.
- Latency from the handshake in cycle k:
  - hit: RD/WR in cycle k+1
  - closed: ACT at k+1, RD/WR at k+1+T_RCD
  - conflict: PRE at k+1, ACT at k+1+T_RP, RD/WR at k+1+T_RP+T_RCD
- Refresh from IDLE at cycle k:
  - banks open: PREA at k+1, REF at k+1+T_RP, refresh_ack at k+1+T_RP+T_RFC
  - no PREA if all banks are closed
- req_ready deasserts the cycle after the handshake. It reasserts in the cycle after RW or after the refresh_ack cycle.

## Structure
- dram_ctrl_pkg holds the cmd encodings (CMD_NOP…CMD_REF) and the state enum. The bank decoder and command logic share these.
- Sub-module dram_open_row_table:
  - per-bank valid bit + RW-bit row register
  - combinational lookup (hit/open) on bank+row
  - single-bank set on ACT
  - clear-all on PREA or reset

## Test plan
- Reset, then read bank 2 row 5 col 3 → ACT(2,5) at k+1, RD(2,col3) at k+3, done pulse; then row 5 of bank 2 is open.
- Second read bank 2 row 5 col 7 → RD at k+1 only, no ACT.
- Write bank 2 row 9 → PRE(2) at k+1, ACT(2,9) at k+3, WR at k+5.
- refresh_req and req_valid both high in IDLE with bank 2 open → req_ready 0, PREA, REF 2 cycles later, refresh_ack 4 cycles after REF. The request is then accepted and issues ACT (table cleared).
- refresh_req rises during the T_RCD wait → the RD completes first, then PREA/REF.
- rst_b pulsed low during the PRE wait → cmd NOP immediately, table cleared. The next request to the same bank issues ACT, not PRE.
